// File: rtl/quadrilatero_rr_lock_arbiter.sv
// Round-robin arbiter that locks the shared resource to one requester until its last beat.
// The grant is issued one cycle after the request, and a one-cycle idle bubble follows every release.
module quadrilatero_rr_lock_arbiter #(
  parameter int unsigned PORTS = 4,
  localparam int unsigned IDX_W = (PORTS > 2) ? $clog2(PORTS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PORTS-1:0] req_i,
  input  logic [PORTS-1:0] last_i,
  input  logic             ready_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             valid_o,
  output logic             beat_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  int unsigned      cand;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      cand     = (32'(ptr_q) + k) % PORTS;
      cand_idx = IDX_W'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    beat_o    = 1'b0;
    busy_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
        end
      end
      LOCKED: begin
        busy_o    = 1'b1;
        gnt_idx_o = owner_q;
        for (int unsigned i = 0; i < PORTS; i++) begin
          gnt_o[i] = (owner_q == IDX_W'(i));
        end
        valid_o = req_i[owner_q];
        beat_o  = req_i[owner_q] & ready_i;
        // Only a completed last beat releases the lock and moves the pointer.
        if (beat_o && last_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = (owner_q == IDX_W'(PORTS - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
    endcase

    // Reset is synchronous, so the outputs are held quiet for the whole reset cycle.
    if (rst_i) begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      beat_o    = 1'b0;
      busy_o    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_quadrilatero_rr_lock_arbiter.sv
// Directed table-driven bench for quadrilatero_rr_lock_arbiter (PORTS = 4).
// Each record holds one cycle's inputs and the outputs expected during that cycle.
module tb_quadrilatero_rr_lock_arbiter;

  localparam int unsigned PORTS = 4;
  localparam int unsigned IDX_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [PORTS-1:0] req_i = '0;
  logic [PORTS-1:0] last_i = '0;
  logic             ready_i = 1'b0;
  logic [PORTS-1:0] gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             valid_o;
  logic             beat_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       beat;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  quadrilatero_rr_lock_arbiter #(.PORTS(PORTS)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .last_i    (last_i),
    .ready_i   (ready_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .valid_o   (valid_o),
    .beat_o    (beat_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] last, logic rdy,
                              logic [3:0] gnt, logic [1:0] idx, logic valid, logic beat,
                              logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.last = last; v.rdy = rdy;
    v.gnt = gnt; v.idx = idx; v.valid = valid; v.beat = beat; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs after the falling edge, compare mid-low-phase, then let the rising edge commit.
  task automatic run(input vec_t v, input string tag);
    @(negedge clk_i);
    rst_i   = v.rst;
    req_i   = v.req;
    last_i  = v.last;
    ready_i = v.rdy;
    #2;
    chk({tag, ".gnt"},   32'(gnt_o),     32'(v.gnt));
    chk({tag, ".idx"},   32'(gnt_idx_o), 32'(v.idx));
    chk({tag, ".valid"}, 32'(valid_o),   32'(v.valid));
    chk({tag, ".beat"},  32'(beat_o),    32'(v.beat));
    chk({tag, ".busy"},  32'(busy_o),    32'(v.busy));
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                     input logic [3:0] last, input logic rdy, input logic [3:0] gnt,
                     input logic [1:0] idx, input logic valid, input logic beat,
                     input logic busy);
    run(mk(rst, req, last, rdy, gnt, idx, valid, beat, busy), tag);
  endtask

  initial begin
    // Reset and single grant to requester 2 (ptr -> 3)
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0));
    // ptr = 3 with requesters 0 and 3: 3 wins, then wrap to 0
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b1000, 3, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1001, 4'b1001, 1, 4'b0001, 0, 1, 1, 1));
    // Reset, then all requesting: order 0,1,2,3,0 with bubbles
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'(1 << (k % 4)), 2'(k % 4), 1, 1, 1));
    end
    // ptr = 1: last without beat is ignored, owner stall, multi-beat, then release
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk(0, 4'b0001, 4'b1111, 1, 4'b0010, 1, 0, 0, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0));

    @(posedge clk_i);
    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // Owner 1, 3-beat transaction with a 2-cycle stall; requester 0 waits for the bubble
    cyc("s32.rst",  1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s32.i0",   0, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s32.g0",   0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 1);
    cyc("s32.idle", 0, 4'b0011, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s32.b1",   0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 1, 1, 1);
    cyc("s32.st1",  0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 1, 0, 1);
    cyc("s32.st2",  0, 4'b0011, 4'b0000, 0, 4'b0010, 1, 1, 0, 1);
    cyc("s32.b2",   0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 1, 1, 1);
    cyc("s32.b3",   0, 4'b0011, 4'b0010, 1, 4'b0010, 1, 1, 1, 1);
    cyc("s32.bub",  0, 4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s32.g0b",  0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 1);

    // ptr = 1: owner 2 drops its request for 4 cycles while others request
    cyc("s34.idle", 0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s34.b1",   0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 1);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("s34.drop%0d", k), 0, 4'b1011, 4'b1111, 1, 4'b0100, 2, 0, 0, 1);
    cyc("s34.last", 0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 1, 1);
    cyc("s34.bub",  0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);

    // ptr = 3: lock owner 1, reset on its last beat; ptr must return to 0, not 2
    cyc("s35.idle", 0, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s35.rst",  1, 4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0, 0);
    cyc("s35.post", 0, 4'b0110, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    cyc("s35.gnt",  0, 4'b0110, 4'b0000, 0, 4'b0010, 1, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
